branch_redirect_controller: RTL and testbench
=============================================

Name: branch_redirect_controller

Overview:
- Consumer of the branch-condition result produced in ID.
- When a control transfer resolves taken, it registers the target, issues a one-cycle PC redirect to IF, and holds the IF/ID flush for a configurable number of cycles.
- If the pipeline is frozen by the hazard unit, the taken decision is parked until the freeze drops.
- Keeps a taken-transfer counter and a sticky misaligned-target flag for debug.

Parameters:
- WORD_LEN, 32, width of PC/target and of the taken counter.
- FLUSH_CYCLES, 1, cycles flushIFID stays asserted per redirect; legal range 1..3.

Ports:
- clk  in  1  pipeline clock, rising-edge.
- rst  in  1  reset, asynchronous, active-high.
- branchValid  in  1  instruction in ID is a control transfer (BEQ/BNE/JUMP/JAL/JR).
- brCond  in  1  condition result for that instruction; 1 = taken.
- brTarget  in  WORD_LEN  resolved target address.
- freeze  in  1  hazard stall; pipeline registers hold.
- pcRedirect  out  1  one-cycle pulse: IF loads redirectPC instead of PC+4.
- redirectPC  out  WORD_LEN  registered target, low 2 bits forced 0.
- flushIFID  out  1  IF/ID register loads a bubble.
- busy  out  1  state != IDLE.
- misalignFlag  out  1  sticky; set when a captured target has bits[1:0] != 0.
- takenCount  out  WORD_LEN  number of redirects issued; wraps.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all outputs 0, held target cleared, flush counter 0. Reset in PENDING or FLUSH discards the pending redirect; no pulse follows reset release.
- Taken event: branchValid & brCond sampled at a rising edge. branchValid=0 or brCond=0 is ignored.
- States:
  - IDLE:
    - Taken event with freeze=0: capture target, go to REDIRECT.
    - Taken event with freeze=1: capture target, go to PENDING.
  - PENDING:
    - Target held. branchValid/brCond ignored (the ID instruction is the same frozen one).
    - Go to REDIRECT at the first edge where freeze=0.
  - REDIRECT (exactly 1 cycle, independent of freeze):
    - pcRedirect=1, flushIFID=1, redirectPC valid. takenCount increments on entry.
    - Go to IDLE if FLUSH_CYCLES=1; otherwise load flush counter with FLUSH_CYCLES-1 and go to FLUSH.
  - FLUSH:
    - flushIFID=1, pcRedirect=0. Counter decrements each cycle; leave for IDLE when it reaches 0.
    - Taken events are ignored because those instructions are being squashed.
- Latency: taken event sampled at edge N (freeze=0) -> pcRedirect/flushIFID high during cycle N+1 -> flushIFID low in cycle N+FLUSH_CYCLES+1.
- First-cycle return: a taken event sampled in the first IDLE cycle after REDIRECT/FLUSH is accepted normally.
- Captured target: stored with bits[1:0] cleared. If the raw bits[1:0] != 0, misalignFlag is set and stays set until reset.
- takenCount: counts REDIRECT entries only; PENDING does not count. Wraps from 2^WORD_LEN-1 to 0.
- redirectPC: holds its last value outside REDIRECT; IF consumes it only with pcRedirect.
- Outputs in IDLE: pcRedirect and flushIFID are 0.
- busy: busy = (state != IDLE).
- Outputs are registered or decoded from registered state only; there is no combinational path from inputs to outputs.

Test Plan:
- Reset, then branchValid=1, brCond=1, brTarget=0x0000_0040, freeze=0 for one cycle -> next cycle pcRedirect=1, flushIFID=1, redirectPC=0x40, takenCount=1; the following cycle both are 0 and busy=0.
- branchValid=1, brCond=0 (BNE not taken), target 0x80 -> no pcRedirect, no flush, takenCount unchanged, busy=0.
- Taken event to 0x100 with freeze=1 held 3 cycles -> busy=1 and pcRedirect=0 during freeze; one cycle after freeze drops, pcRedirect=1 with redirectPC=0x100; takenCount=1.
- FLUSH_CYCLES=3, taken event to 0x200, second taken event to 0x300 presented during FLUSH -> flushIFID high for exactly 3 cycles, only 0x200 redirected; a taken event to 0x300 presented in the first IDLE cycle after the flush is redirected.
- Target 0x0000_0046 -> redirectPC=0x44, misalignFlag=1 and stays 1 after later aligned branches; rst clears it.
- Assert rst asynchronously mid-PENDING (target 0x500, freeze=1) -> outputs 0 immediately without a clock edge; after release with freeze=0, no redirect occurs, takenCount=0.

Source files
------------

// File: rtl/branch_redirect_controller.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_controller
// Purpose  : Turns a taken control transfer resolved in ID into a one-cycle PC
//            redirect and a multi-cycle IF/ID flush. A taken decision seen
//            while the pipeline is frozen is parked until the freeze drops.
//            Also keeps a taken-redirect counter and a sticky misaligned-target
//            flag for debug.
// Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_controller #(
  parameter int WORD_LEN     = 32,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                branchValid,
  input  logic                brCond,
  input  logic [WORD_LEN-1:0] brTarget,
  input  logic                freeze,
  output logic                pcRedirect,
  output logic [WORD_LEN-1:0] redirectPC,
  output logic                flushIFID,
  output logic                busy,
  output logic                misalignFlag,
  output logic [WORD_LEN-1:0] takenCount
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PENDING  = 2'd1,
    ST_REDIRECT = 2'd2,
    ST_FLUSH    = 2'd3
  } state_t;

  // Flush cycles remaining after the REDIRECT cycle itself (range 0..2).
  localparam logic [1:0]          C_FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);
  localparam logic [WORD_LEN-1:0] C_ONE        = WORD_LEN'(1);

  state_t              state_q, state_d;
  logic [WORD_LEN-1:0] target_q, target_d;
  logic [WORD_LEN-1:0] redirect_pc_q, redirect_pc_d;
  logic [1:0]          flush_cnt_q, flush_cnt_d;
  logic [WORD_LEN-1:0] count_q, count_d;
  logic                misalign_q, misalign_d;
  logic                pc_redirect_q, pc_redirect_d;
  logic                flush_q, flush_d;
  logic                busy_q, busy_d;

  logic                taken;
  logic [WORD_LEN-1:0] aligned_target;

  assign taken          = branchValid & brCond;
  assign aligned_target = {brTarget[WORD_LEN-1:2], 2'b00};

  // Next-state logic: target capture, redirect issue, flush countdown, debug state
  always_comb begin
    state_d       = state_q;
    target_d      = target_q;
    redirect_pc_d = redirect_pc_q;
    flush_cnt_d   = flush_cnt_q;
    count_d       = count_q;
    misalign_d    = misalign_q;

    case (state_q)
      ST_IDLE: begin
        if (taken) begin
          target_d = aligned_target;
          if (brTarget[1:0] != 2'b00) begin
            misalign_d = 1'b1;
          end
          if (freeze) begin
            state_d = ST_PENDING;
          end else begin
            state_d       = ST_REDIRECT;
            redirect_pc_d = aligned_target;
            count_d       = count_q + C_ONE;
          end
        end
      end

      ST_PENDING: begin
        // The frozen ID instruction is the one already captured; ignore its inputs.
        if (!freeze) begin
          state_d       = ST_REDIRECT;
          redirect_pc_d = target_q;
          count_d       = count_q + C_ONE;
        end
      end

      ST_REDIRECT: begin
        if (FLUSH_CYCLES > 1) begin
          flush_cnt_d = C_FLUSH_LOAD;
          state_d     = ST_FLUSH;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_FLUSH: begin
        // Instructions arriving here are being squashed, so taken events are dropped.
        flush_cnt_d = flush_cnt_q - 2'd1;
        if (flush_cnt_q <= 2'd1) begin
          flush_cnt_d = 2'd0;
          state_d     = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Outputs are registered versions of the next-state decode.
    pc_redirect_d = (state_d == ST_REDIRECT);
    flush_d       = (state_d == ST_REDIRECT) || (state_d == ST_FLUSH);
    busy_d        = (state_d != ST_IDLE);
  end

  // State and output registers; reset discards any parked or in-flight redirect
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      target_q      <= '0;
      redirect_pc_q <= '0;
      flush_cnt_q   <= 2'd0;
      count_q       <= '0;
      misalign_q    <= 1'b0;
      pc_redirect_q <= 1'b0;
      flush_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      target_q      <= target_d;
      redirect_pc_q <= redirect_pc_d;
      flush_cnt_q   <= flush_cnt_d;
      count_q       <= count_d;
      misalign_q    <= misalign_d;
      pc_redirect_q <= pc_redirect_d;
      flush_q       <= flush_d;
      busy_q        <= busy_d;
    end
  end

  assign pcRedirect   = pc_redirect_q;
  assign redirectPC   = redirect_pc_q;
  assign flushIFID    = flush_q;
  assign busy         = busy_q;
  assign misalignFlag = misalign_q;
  assign takenCount   = count_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_redirect_controller
// Purpose  : Directed, table-driven bench for branch_redirect_controller.
//            One instance uses FLUSH_CYCLES=1, a second uses FLUSH_CYCLES=3;
//            both share the same stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        branchValid;
  logic        brCond;
  logic [31:0] brTarget;
  logic        freeze;

  logic        red1, fl1, busy1, mis1;
  logic [31:0] pc1, cnt1;
  logic        red3, fl3, busy3, mis3;
  logic [31:0] pc3, cnt3;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branch_redirect_controller #(.WORD_LEN(32), .FLUSH_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .branchValid(branchValid), .brCond(brCond),
    .brTarget(brTarget), .freeze(freeze), .pcRedirect(red1), .redirectPC(pc1),
    .flushIFID(fl1), .busy(busy1), .misalignFlag(mis1), .takenCount(cnt1)
  );

  branch_redirect_controller #(.WORD_LEN(32), .FLUSH_CYCLES(3)) dut3 (
    .clk(clk), .rst(rst), .branchValid(branchValid), .brCond(brCond),
    .brTarget(brTarget), .freeze(freeze), .pcRedirect(red3), .redirectPC(pc3),
    .flushIFID(fl3), .busy(busy3), .misalignFlag(mis3), .takenCount(cnt3)
  );

  typedef struct {
    logic        bv;
    logic        bc;
    logic [31:0] tgt;
    logic        frz;
    logic        e_red;
    logic        e_fl;
    logic [31:0] e_pc;
    logic        e_busy;
    logic        e_mis;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic bv, input logic bc, input logic [31:0] tgt, input logic frz);
    branchValid = bv;
    brCond      = bc;
    brTarget    = tgt;
    freeze      = frz;
  endtask

  // Advance one rising edge and settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic chk1(input string tag, input logic r, input logic f, input logic [31:0] pc,
                      input logic b, input logic m, input logic [31:0] c);
    chk({tag, ".pcRedirect"}, {31'd0, red1}, {31'd0, r});
    chk({tag, ".flushIFID"}, {31'd0, fl1}, {31'd0, f});
    chk({tag, ".redirectPC"}, pc1, pc);
    chk({tag, ".busy"}, {31'd0, busy1}, {31'd0, b});
    chk({tag, ".misalign"}, {31'd0, mis1}, {31'd0, m});
    chk({tag, ".takenCount"}, cnt1, c);
  endtask

  task automatic chk3(input string tag, input logic r, input logic f, input logic [31:0] pc,
                      input logic b, input logic [31:0] c);
    chk({tag, ".pcRedirect"}, {31'd0, red3}, {31'd0, r});
    chk({tag, ".flushIFID"}, {31'd0, fl3}, {31'd0, f});
    chk({tag, ".redirectPC"}, pc3, pc);
    chk({tag, ".busy"}, {31'd0, busy3}, {31'd0, b});
    chk({tag, ".takenCount"}, cnt3, c);
  endtask

  initial begin
    // bv bc target frz | red fl pc busy mis cnt   (FLUSH_CYCLES=1 instance)
    vecs[0]  = '{1'b1, 1'b1, 32'h40,  1'b0, 1'b1, 1'b1, 32'h40,  1'b1, 1'b0, 32'd1};
    vecs[1]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h40,  1'b0, 1'b0, 32'd1};
    vecs[2]  = '{1'b1, 1'b0, 32'h80,  1'b0, 1'b0, 1'b0, 32'h40,  1'b0, 1'b0, 32'd1};
    vecs[3]  = '{1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h40,  1'b1, 1'b0, 32'd1};
    vecs[4]  = '{1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 1'b0, 32'h40,  1'b1, 1'b0, 32'd1};
    vecs[5]  = '{1'b0, 1'b0, 32'h0,   1'b1, 1'b0, 1'b0, 32'h40,  1'b1, 1'b0, 32'd1};
    vecs[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b1, 1'b1, 32'h100, 1'b1, 1'b0, 32'd2};
    vecs[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h100, 1'b0, 1'b0, 32'd2};
    vecs[8]  = '{1'b1, 1'b1, 32'h46,  1'b0, 1'b1, 1'b1, 32'h44,  1'b1, 1'b1, 32'd3};
    vecs[9]  = '{1'b1, 1'b1, 32'h48,  1'b0, 1'b0, 1'b0, 32'h44,  1'b0, 1'b1, 32'd3};
    vecs[10] = '{1'b1, 1'b1, 32'h48,  1'b0, 1'b1, 1'b1, 32'h48,  1'b1, 1'b1, 32'd4};
    vecs[11] = '{1'b0, 1'b0, 32'h0,   1'b0, 1'b0, 1'b0, 32'h48,  1'b0, 1'b1, 32'd4};

    rst = 1'b1;
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    #1;
    chk1("por", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    chk3("por3", 1'b0, 1'b0, 32'h0, 1'b0, 32'd0);
    do_reset();

    // Table: FLUSH_CYCLES=1 instance, each vector sampled one edge after drive.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].bv, vecs[i].bc, vecs[i].tgt, vecs[i].frz);
      step();
      chk1($sformatf("vec%0d", i), vecs[i].e_red, vecs[i].e_fl, vecs[i].e_pc,
           vecs[i].e_busy, vecs[i].e_mis, vecs[i].e_cnt);
    end

    // Asynchronous reset while a redirect is parked in PENDING.
    drive(1'b1, 1'b1, 32'h500, 1'b1);
    step();
    chk1("pend", 1'b0, 1'b0, 32'h48, 1'b1, 1'b1, 32'd4);
    drive(1'b0, 1'b0, 32'h0, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    chk1("arst", 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    step();
    freeze = 1'b0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1($sformatf("post_rst%0d", i), 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'd0);
    end

    // FLUSH_CYCLES=3: second taken during FLUSH is dropped, accepted in first IDLE cycle.
    do_reset();
    drive(1'b1, 1'b1, 32'h200, 1'b0);
    step();
    chk3("f3_redir", 1'b1, 1'b1, 32'h200, 1'b1, 32'd1);
    drive(1'b1, 1'b1, 32'h300, 1'b0);
    step();
    chk3("f3_flush1", 1'b0, 1'b1, 32'h200, 1'b1, 32'd1);
    step();
    chk3("f3_flush2", 1'b0, 1'b1, 32'h200, 1'b1, 32'd1);
    step();
    chk3("f3_idle", 1'b0, 1'b0, 32'h200, 1'b0, 32'd1);
    step();
    chk3("f3_redir2", 1'b1, 1'b1, 32'h300, 1'b1, 32'd2);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk3("f3_flush3", 1'b0, 1'b1, 32'h300, 1'b1, 32'd2);
    step();
    step();
    chk3("f3_done", 1'b0, 1'b0, 32'h300, 1'b0, 32'd2);

    // FLUSH_CYCLES=3 with freeze: parked target redirected after freeze drops.
    drive(1'b1, 1'b1, 32'h103, 1'b1);
    step();
    chk3("f3_pend", 1'b0, 1'b0, 32'h300, 1'b1, 32'd2);
    chk("f3_mis", {31'd0, mis3}, 32'd1);
    drive(1'b0, 1'b0, 32'h0, 1'b0);
    step();
    chk3("f3_unfrz", 1'b1, 1'b1, 32'h100, 1'b1, 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
